// File: rtl/ndp_pkg.sv
// Shared definitions for the NDP tile sequencer: FSM state encoding and drain-depth helper.
package ndp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        RESULT
    } seq_state_t;

    function automatic int unsigned drain_depth(input int unsigned arr_width,
                                                input int unsigned arr_height);
        return arr_width + arr_height;
    endfunction

endpackage

// File: rtl/ndp_beat_aligner.sv
// One-cycle operand register between the operand memories and the NDP unit.
// Ungranted cycles become zero bubbles flagged by in_done_flag.
module ndp_beat_aligner #(
    parameter int unsigned A_W = 64,
    parameter int unsigned B_W = 4096
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rd_fire,
    input  logic [A_W-1:0] rd_a,
    input  logic [B_W-1:0] rd_b,
    output logic [A_W-1:0] in_a,
    output logic [B_W-1:0] in_b,
    output logic           in_done_flag
);

    logic           beat_v;
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_v <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            beat_v <= rd_fire;
            a_q    <= rd_a;
            b_q    <= rd_b;
        end
    end

    // Masking keeps A and B aligned: a bubble contributes 0*0 to every accumulator.
    assign in_a         = a_q & {A_W{beat_v}};
    assign in_b         = b_q & {B_W{beat_v}};
    assign in_done_flag = ~beat_v;

endmodule

// File: rtl/ndp_tile_sequencer.sv
// Runs one NDP output tile per command: clear, K operand reads, drain, result handshake.
// Optional NDP_SEQ_PERF_EN adds perf_tiles / perf_stalls counters.
module ndp_tile_sequencer
    import ndp_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ARR_WIDTH  = 4,
    parameter int unsigned ARR_HEIGHT = 4,
    parameter int unsigned SYS_WIDTH  = 64,
    parameter int unsigned SYS_HEIGHT = 1,
    parameter int unsigned K_BITS     = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [K_BITS-1:0]                     cmd_k_len,
    output logic                                  op_rd_en,
    output logic [K_BITS-1:0]                     op_rd_addr,
    input  logic                                  op_rd_gnt,
    input  logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0] op_rd_a,
    input  logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]   op_rd_b,
    output logic                                  ndp_reset,
    output logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0] ndp_in_a,
    output logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]   ndp_in_b,
    output logic                                  ndp_in_done_flag,
    input  logic                                  ndp_calc_done_flag,
    output logic                                  res_valid,
    input  logic                                  res_ready
`ifdef NDP_SEQ_PERF_EN
    ,
    output logic [31:0]                           perf_tiles,
    output logic [31:0]                           perf_stalls
`endif
);

    localparam int unsigned A_W = ARR_HEIGHT * SYS_HEIGHT * WIDTH;
    localparam int unsigned B_W = ARR_WIDTH * SYS_WIDTH * WIDTH;
    localparam int unsigned D   = drain_depth(ARR_WIDTH, ARR_HEIGHT);
    localparam int unsigned DCW = $clog2(D + 1);
    localparam logic [DCW-1:0] D_CNT = DCW'(D);

    seq_state_t        state, state_nxt;
    logic [K_BITS-1:0] k_len_q;
    logic [K_BITS-1:0] issue_cnt;
    logic [DCW-1:0]    drain_cnt;

    logic              cmd_ready_s;
    logic              rd_en_s;
    logic [K_BITS-1:0] rd_addr_s;
    logic              res_valid_s;
    logic              clear_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k_len_q   <= '0;
            issue_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        k_len_q <= cmd_k_len;
                    end
                end
                CLEAR: begin
                    issue_cnt <= '0;
                    drain_cnt <= '0;
                end
                FEED: begin
                    if (op_rd_gnt) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (ndp_in_done_flag && (drain_cnt != D_CNT)) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_s = 1'b0;
        rd_en_s     = 1'b0;
        rd_addr_s   = '0;
        res_valid_s = 1'b0;
        clear_s     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clear_s   = 1'b1;
                state_nxt = (k_len_q != '0) ? FEED : DRAIN;
            end
            FEED: begin
                rd_en_s   = 1'b1;
                rd_addr_s = issue_cnt;
                if (op_rd_gnt && (issue_cnt == k_len_q - 1'b1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Done pulses from mid-feed bubbles never reach here; only a full drain counts.
                if ((drain_cnt == D_CNT) && ndp_calc_done_flag) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                res_valid_s = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready  = cmd_ready_s & ~reset;
    assign op_rd_en   = rd_en_s & ~reset;
    assign op_rd_addr = reset ? '0 : rd_addr_s;
    assign res_valid  = res_valid_s & ~reset;
    assign ndp_reset  = reset | clear_s;

    ndp_beat_aligner #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_beat_aligner (
        .clk          (clk),
        .reset        (reset),
        .rd_fire      (op_rd_gnt & op_rd_en),
        .rd_a         (op_rd_a),
        .rd_b         (op_rd_b),
        .in_a         (ndp_in_a),
        .in_b         (ndp_in_b),
        .in_done_flag (ndp_in_done_flag)
    );

`ifdef NDP_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_tiles  <= '0;
            perf_stalls <= '0;
        end else begin
            if ((state == RESULT) && res_ready) begin
                perf_tiles <= perf_tiles + 1'b1;
            end
            if ((state == FEED) && !op_rd_gnt) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ndp_tile_sequencer.sv
// Self-checking bench for ndp_tile_sequencer with a behavioural NDP/memory model.
module tb_ndp_tile_sequencer;

    localparam int WIDTH      = 16;
    localparam int ARR_WIDTH  = 4;
    localparam int ARR_HEIGHT = 4;
    localparam int SYS_WIDTH  = 2;
    localparam int SYS_HEIGHT = 1;
    localparam int K_BITS     = 16;
    localparam int ROWS = ARR_HEIGHT * SYS_HEIGHT;
    localparam int COLS = ARR_WIDTH * SYS_WIDTH;
    localparam int A_W  = ROWS * WIDTH;
    localparam int B_W  = COLS * WIDTH;
    localparam int D    = ARR_WIDTH + ARR_HEIGHT;
    localparam int MAXK = 64;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [K_BITS-1:0] cmd_k_len;
    logic              op_rd_en;
    logic [K_BITS-1:0] op_rd_addr;
    logic              op_rd_gnt;
    logic [A_W-1:0]    op_rd_a;
    logic [B_W-1:0]    op_rd_b;
    logic              ndp_reset;
    logic [A_W-1:0]    ndp_in_a;
    logic [B_W-1:0]    ndp_in_b;
    logic              ndp_in_done_flag;
    logic              ndp_calc_done_flag;
    logic              res_valid;
    logic              res_ready;
`ifdef NDP_SEQ_PERF_EN
    logic [31:0]       perf_tiles;
    logic [31:0]       perf_stalls;
`endif

    ndp_tile_sequencer #(
        .WIDTH      (WIDTH),
        .ARR_WIDTH  (ARR_WIDTH),
        .ARR_HEIGHT (ARR_HEIGHT),
        .SYS_WIDTH  (SYS_WIDTH),
        .SYS_HEIGHT (SYS_HEIGHT),
        .K_BITS     (K_BITS)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_k_len          (cmd_k_len),
        .op_rd_en           (op_rd_en),
        .op_rd_addr         (op_rd_addr),
        .op_rd_gnt          (op_rd_gnt),
        .op_rd_a            (op_rd_a),
        .op_rd_b            (op_rd_b),
        .ndp_reset          (ndp_reset),
        .ndp_in_a           (ndp_in_a),
        .ndp_in_b           (ndp_in_b),
        .ndp_in_done_flag   (ndp_in_done_flag),
        .ndp_calc_done_flag (ndp_calc_done_flag),
        .res_valid          (res_valid),
        .res_ready          (res_ready)
`ifdef NDP_SEQ_PERF_EN
        ,
        .perf_tiles         (perf_tiles),
        .perf_stalls        (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [A_W-1:0] mem_a [MAXK];
    logic [B_W-1:0] mem_b [MAXK];
    longint         acc [ROWS][COLS];
    int             run_len = 0;
    int             lat_l   = 1;
    int             exp_tiles  = 0;
    int             exp_stalls = 0;

    // NDP unit stand-in: accumulates in_a x in_b outer product every cycle, and
    // raises calc_done after lat_l consecutive done-flag cycles since a clear/beat.
    task automatic ndp_model_step(input bit noise);
        if (ndp_reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    acc[r][c] = 0;
            run_len = 0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    acc[r][c] += longint'(ndp_in_a[r*WIDTH +: WIDTH]) *
                                 longint'(ndp_in_b[c*WIDTH +: WIDTH]);
            if (ndp_in_done_flag) run_len++;
            else run_len = 0;
        end
        ndp_calc_done_flag = (!ndp_reset && (run_len >= lat_l)) || noise;
    endtask

    function automatic longint ref_c(input int r, input int c, input int k);
        longint s = 0;
        for (int t = 0; t < k; t++)
            s += longint'(mem_a[t][r*WIDTH +: WIDTH]) * longint'(mem_b[t][c*WIDTH +: WIDTH]);
        return s;
    endfunction

    function automatic int acc_errors(input int k);
        int e = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (acc[r][c] != ref_c(r, c, k)) e++;
        return e;
    endfunction

    function automatic logic [A_W-1:0] rand_a();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [B_W-1:0] rand_b();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // gmode: 0 grant always, 1 random grant, 2 stall only the second request.
    task automatic run_tile(input int k, input int gmode, input int lat, input int hold,
                            input bit early_cmd, input bit noisy);
        int cyc, grants, stalls, beat_idx, exp_rv, nerr, mx;
        bit last_gnt, finished, feed, g, exp_valid, noise;
        logic [A_W-1:0] exp_a;
        logic [B_W-1:0] exp_b;
        for (int t = 0; t < k; t++) begin
            mem_a[t] = rand_a();
            mem_b[t] = rand_b();
        end
        lat_l = lat;
        mx = (D > lat - 1) ? D : lat - 1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_ready_idle k=%0d got=%b exp=1", k, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_k_len = K_BITS'(k);
        op_rd_gnt = 1'b0;
        res_ready = 1'b0;
        ndp_model_step(1'b0);
        @(posedge clk);
        cyc = 1; grants = 0; stalls = 0; beat_idx = 0;
        last_gnt = 0; finished = 0;
        exp_rv = (k == 0) ? (2 + mx + 1) : -1;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cmd_valid = early_cmd && (exp_rv >= 0) && (cyc >= exp_rv);
            feed = (cyc >= 2) && (grants < k);
            n_cmp++;
            if ({ndp_reset, op_rd_en} !== {cyc == 1, feed} ||
                (feed && op_rd_addr !== K_BITS'(grants))) begin
                n_err++;
                $display("FAIL rd_req cyc=%0d got rst/en/addr=%b/%b/%0d exp=%b/%b/%0d",
                         cyc, ndp_reset, op_rd_en, op_rd_addr, cyc == 1, feed, grants);
            end
            exp_a = last_gnt ? mem_a[beat_idx] : '0;
            exp_b = last_gnt ? mem_b[beat_idx] : '0;
            n_cmp++;
            if ({ndp_in_done_flag, ndp_in_a, ndp_in_b} !== {!last_gnt, exp_a, exp_b}) begin
                n_err++;
                $display("FAIL beat cyc=%0d got done=%b a=%h b=%h exp done=%b a=%h b=%h",
                         cyc, ndp_in_done_flag, ndp_in_a, ndp_in_b, !last_gnt, exp_a, exp_b);
            end
            if (last_gnt) beat_idx++;
            exp_valid = (exp_rv >= 0) && (cyc >= exp_rv);
            n_cmp++;
            if ({res_valid, cmd_ready} !== {exp_valid, 1'b0}) begin
                n_err++;
                $display("FAIL res_valid cyc=%0d got valid/cmd_ready=%b/%b exp=%b/0",
                         cyc, res_valid, cmd_ready, exp_valid);
            end
            if (exp_valid) begin
                nerr = acc_errors(k);
                n_cmp++;
                if (nerr != 0) begin
                    n_err++;
                    $display("FAIL out_c cyc=%0d k=%0d got %0d wrong elements exp 0", cyc, k, nerr);
                end
                res_ready = (cyc - exp_rv) >= hold;
                if (res_ready) begin
                    finished = 1;
                    exp_tiles++;
                    exp_stalls += stalls;
                end
            end else begin
                res_ready = $urandom_range(0, 1);
            end
            if (feed) begin
                case (gmode)
                    0:       g = 1'b1;
                    1:       g = ($urandom_range(0, 2) != 0);
                    default: g = !(grants == 1 && stalls == 0);
                endcase
                op_rd_gnt = g;
                op_rd_a   = mem_a[grants];
                op_rd_b   = mem_b[grants];
                if (g) begin
                    grants++;
                    if (grants == k) exp_rv = (cyc + 2) + mx + 1;
                end else begin
                    stalls++;
                end
                last_gnt = g;
            end else begin
                op_rd_gnt = $urandom_range(0, 1);
                op_rd_a   = rand_a();
                op_rd_b   = rand_b();
                last_gnt  = 1'b0;
            end
            noise = noisy && feed && ($urandom_range(0, 2) == 0);
            ndp_model_step(noise);
            @(posedge clk);
            cyc++;
        end
        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout k=%0d got no handshake within %0d cycles exp handshake", k, cyc);
        end
`ifdef NDP_SEQ_PERF_EN
        #1;
        n_cmp++;
        if (perf_tiles !== 32'(exp_tiles) || perf_stalls !== 32'(exp_stalls)) begin
            n_err++;
            $display("FAIL perf got tiles/stalls=%0d/%0d exp=%0d/%0d",
                     perf_tiles, perf_stalls, exp_tiles, exp_stalls);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_k_len = '0;
        op_rd_gnt = 1'b0;
        op_rd_a = '0;
        op_rd_b = '0;
        res_ready = 1'b0;
        ndp_calc_done_flag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, op_rd_en, op_rd_addr, ndp_in_a, ndp_in_b, ndp_in_done_flag, res_valid, ndp_reset}
            !== {1'b0, 1'b0, K_BITS'(0), A_W'(0), B_W'(0), 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b en=%b addr=%0d done=%b rv=%b nrst=%b a|b=%b",
                     cmd_ready, op_rd_en, op_rd_addr, ndp_in_done_flag, res_valid, ndp_reset,
                     (|ndp_in_a) | (|ndp_in_b));
        end
        ndp_model_step(1'b0);
        reset = 1'b0;
        exp_tiles = 0;
        exp_stalls = 0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, ndp_reset, res_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL post_reset got rdy/nrst/rv=%b%b%b exp=100", cmd_ready, ndp_reset, res_valid);
        end
        ndp_model_step(1'b0);
        @(posedge clk);
    endtask

    task automatic test_k3_nostall();
        run_tile(3, 0, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_k4_stall();
        run_tile(4, 2, D + 2, 1, 1'b0, 1'b0);
    endtask

    task automatic test_k0();
        run_tile(0, 0, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_hold_back_to_back();
        run_tile(5, 1, 3, 10, 1'b1, 1'b1);
        run_tile(2, 0, D + 3, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_feed();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_k_len = K_BITS'(6);
        res_ready = 1'b0;
        ndp_model_step(1'b0);
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            op_rd_gnt = 1'b1;
            op_rd_a = rand_a();
            op_rd_b = rand_b();
            ndp_model_step(1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ndp_reset, cmd_ready, op_rd_en} !== 3'b100) begin
            n_err++;
            $display("FAIL mid_reset got nrst/rdy/en=%b%b%b exp=100", ndp_reset, cmd_ready, op_rd_en);
        end
        ndp_model_step(1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        op_rd_gnt = 1'b0;
        exp_tiles = 0;
        exp_stalls = 0;
        #1;
        n_cmp++;
        if ({op_rd_en, ndp_in_done_flag, cmd_ready, res_valid, ndp_reset} !== 5'b01100) begin
            n_err++;
            $display("FAIL after_mid_reset got en/done/rdy/rv/nrst=%b%b%b%b%b exp=01100",
                     op_rd_en, ndp_in_done_flag, cmd_ready, res_valid, ndp_reset);
        end
        ndp_model_step(1'b0);
        @(posedge clk);
        run_tile(2, 0, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_tile($urandom_range(0, 12), $urandom_range(0, 1), $urandom_range(1, D + 3),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        test_reset();
        test_k3_nostall();
        test_k4_stall();
        test_k0();
        test_hold_back_to_back();
        test_reset_mid_feed();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
